// File: rtl/ex_result_stage_pkg.sv
// Shared definitions for the execute result stage: word width, enable levels,
// decoded op encodings and result-buffer state encodings.
package ex_result_stage_pkg;

    localparam int unsigned WORD_DATA = 32;
    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpXor  = 4'd4,
        OpSll  = 4'd5,
        OpSrl  = 4'd6,
        OpSlt  = 4'd7,
        OpSltu = 4'd8,
        OpBeq  = 4'd9,
        OpBne  = 4'd10,
        OpBlt  = 4'd11,
        OpBge  = 4'd12,
        OpBltu = 4'd13,
        OpBgeu = 4'd14,
        OpNop  = 4'd15
    } ex_op_e;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/ex_result_sel.sv
// Combinational result selector: maps the decoded op onto the parallel ALU
// outputs, resolves the branch condition and forms the branch target.
module ex_result_sel
    import ex_result_stage_pkg::*;
#(
    parameter int unsigned OP_W = 4,
    parameter int unsigned RD_W = 5
) (
    input  logic [OP_W-1:0]      op,
    input  logic [RD_W-1:0]      rd,
    input  logic [WORD_DATA-1:0] pc,
    input  logic [WORD_DATA-1:0] imm,
    input  logic [WORD_DATA-1:0] alu_add,
    input  logic [WORD_DATA-1:0] alu_sub,
    input  logic [WORD_DATA-1:0] alu_and,
    input  logic [WORD_DATA-1:0] alu_or,
    input  logic [WORD_DATA-1:0] alu_xor,
    input  logic [WORD_DATA-1:0] alu_sll,
    input  logic [WORD_DATA-1:0] alu_srl,
    input  logic [WORD_DATA-1:0] alu_slt,
    input  logic [WORD_DATA-1:0] alu_sltu,
    input  logic                 alu_eq,
    output logic [WORD_DATA-1:0] result,
    output logic [RD_W-1:0]      wb_rd,
    output logic                 wen,
    output logic                 br_taken,
    output logic [WORD_DATA-1:0] br_target
);

    // Target is formed for every op; it only matters when the branch is taken.
    assign br_target = pc + imm;

    // Decode op into result, write enable and branch outcome.
    always_comb begin
        result   = '0;
        wen      = DISABLE;
        br_taken = DISABLE;
        case (op)
            OP_W'(OpAdd):  begin result = alu_add;  wen = ENABLE; end
            OP_W'(OpSub):  begin result = alu_sub;  wen = ENABLE; end
            OP_W'(OpAnd):  begin result = alu_and;  wen = ENABLE; end
            OP_W'(OpOr):   begin result = alu_or;   wen = ENABLE; end
            OP_W'(OpXor):  begin result = alu_xor;  wen = ENABLE; end
            OP_W'(OpSll):  begin result = alu_sll;  wen = ENABLE; end
            OP_W'(OpSrl):  begin result = alu_srl;  wen = ENABLE; end
            OP_W'(OpSlt):  begin result = alu_slt;  wen = ENABLE; end
            OP_W'(OpSltu): begin result = alu_sltu; wen = ENABLE; end
            OP_W'(OpBeq):  br_taken = alu_eq;
            OP_W'(OpBne):  br_taken = ~alu_eq;
            OP_W'(OpBlt):  br_taken = alu_slt[0];
            OP_W'(OpBge):  br_taken = ~alu_slt[0];
            OP_W'(OpBltu): br_taken = alu_sltu[0];
            OP_W'(OpBgeu): br_taken = ~alu_sltu[0];
            default: ; // NOP: occupies a slot, writes nothing
        endcase
    end

    // Non-writing entries carry rd=0 so downstream forwarding never matches them.
    assign wb_rd = wen ? rd : '0;

endmodule

// File: rtl/ex_result_stage.sv
// EX/MEM result stage: selects the ALU result for the decoded op and holds it
// in a valid/ready buffer feeding the memory stage.
// Build option EX_SKID_EN: defined gives a two-entry skid buffer with a
// registered in_ready; undefined gives a single entry register whose in_ready
// is combinational (!out_valid | out_ready).
module ex_result_stage
    import ex_result_stage_pkg::*;
#(
    parameter int unsigned OP_W = 4,
    parameter int unsigned RD_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      in_op,
    input  logic [RD_W-1:0]      in_rd,
    input  logic [WORD_DATA-1:0] in_pc,
    input  logic [WORD_DATA-1:0] in_imm,
    input  logic [WORD_DATA-1:0] alu_add,
    input  logic [WORD_DATA-1:0] alu_sub,
    input  logic [WORD_DATA-1:0] alu_and,
    input  logic [WORD_DATA-1:0] alu_or,
    input  logic [WORD_DATA-1:0] alu_xor,
    input  logic [WORD_DATA-1:0] alu_sll,
    input  logic [WORD_DATA-1:0] alu_srl,
    input  logic [WORD_DATA-1:0] alu_slt,
    input  logic [WORD_DATA-1:0] alu_sltu,
    input  logic                 alu_eq,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_DATA-1:0] out_result,
    output logic [RD_W-1:0]      out_rd,
    output logic                 out_wen,
    output logic                 out_br_taken,
    output logic [WORD_DATA-1:0] out_br_target
);

    typedef struct packed {
        logic [WORD_DATA-1:0] result;
        logic [RD_W-1:0]      rd;
        logic                 wen;
        logic                 br_taken;
        logic [WORD_DATA-1:0] br_target;
    } entry_t;

    entry_t               new_entry;
    entry_t               head_q, head_d;
    buf_state_e           state_q, state_d;
    logic                 push, pop;
    logic [WORD_DATA-1:0] sel_result;
    logic [RD_W-1:0]      sel_rd;
    logic                 sel_wen;
    logic                 sel_taken;
    logic [WORD_DATA-1:0] sel_target;

    ex_result_sel #(
        .OP_W (OP_W),
        .RD_W (RD_W)
    ) u_sel (
        .op        (in_op),
        .rd        (in_rd),
        .pc        (in_pc),
        .imm       (in_imm),
        .alu_add   (alu_add),
        .alu_sub   (alu_sub),
        .alu_and   (alu_and),
        .alu_or    (alu_or),
        .alu_xor   (alu_xor),
        .alu_sll   (alu_sll),
        .alu_srl   (alu_srl),
        .alu_slt   (alu_slt),
        .alu_sltu  (alu_sltu),
        .alu_eq    (alu_eq),
        .result    (sel_result),
        .wb_rd     (sel_rd),
        .wen       (sel_wen),
        .br_taken  (sel_taken),
        .br_target (sel_target)
    );

    assign new_entry = '{
        result:    sel_result,
        rd:        sel_rd,
        wen:       sel_wen,
        br_taken:  sel_taken,
        br_target: sel_target
    };

    assign out_valid = (state_q != StEmpty);
    // Flush blocks acceptance even though in_ready may still read high.
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

`ifdef EX_SKID_EN
    entry_t skid_q, skid_d;
    logic   in_ready_q;

    // Skid buffer next state: the second slot catches the entry that was in
    // flight when downstream stalled.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d = StOne;
                        head_d  = new_entry;
                    end
                end
                StOne: begin
                    if (push && !pop) begin
                        state_d = StTwo;
                        skid_d  = new_entry;
                    end else if (push && pop) begin
                        head_d = new_entry;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        state_d = StOne;
                        head_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // State, payload and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != StTwo);
        end
    end

    assign in_ready = in_ready_q;
`else
    // Single entry: a simultaneous push and pop simply replaces the entry.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        if (flush) begin
            state_d = StEmpty;
        end else if (push) begin
            state_d = StOne;
            head_d  = new_entry;
        end else if (pop) begin
            state_d = StEmpty;
        end
    end

    // State and payload register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            head_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
        end
    end

    assign in_ready = (state_q == StEmpty) | out_ready;
`endif

    assign out_result    = head_q.result;
    assign out_rd        = head_q.rd;
    assign out_wen       = head_q.wen;
    assign out_br_taken  = head_q.br_taken;
    assign out_br_target = head_q.br_target;

endmodule

// File: tb/tb_ex_result_stage.sv
// Scoreboard bench for ex_result_stage: expected entries are queued on accept
// and compared against the head while it is valid and when it pops.
module tb_ex_result_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [31:0] in_pc, in_imm;
    logic [31:0] alu_add, alu_sub, alu_and, alu_or, alu_xor;
    logic [31:0] alu_sll, alu_srl, alu_slt, alu_sltu;
    logic        alu_eq;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen, out_br_taken;
    logic [31:0] out_br_target;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wen;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ex_result_stage #(
        .OP_W (4),
        .RD_W (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_rd         (in_rd),
        .in_pc         (in_pc),
        .in_imm        (in_imm),
        .alu_add       (alu_add),
        .alu_sub       (alu_sub),
        .alu_and       (alu_and),
        .alu_or        (alu_or),
        .alu_xor       (alu_xor),
        .alu_sll       (alu_sll),
        .alu_srl       (alu_srl),
        .alu_slt       (alu_slt),
        .alu_sltu      (alu_sltu),
        .alu_eq        (alu_eq),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_wen       (out_wen),
        .out_br_taken  (out_br_taken),
        .out_br_target (out_br_target)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of one entry from the current inputs.
    function automatic exp_t model();
        exp_t e;
        e.result = 32'h0;
        e.wen    = 1'b0;
        e.taken  = 1'b0;
        case (in_op)
            4'd0:  begin e.result = alu_add;  e.wen = 1'b1; end
            4'd1:  begin e.result = alu_sub;  e.wen = 1'b1; end
            4'd2:  begin e.result = alu_and;  e.wen = 1'b1; end
            4'd3:  begin e.result = alu_or;   e.wen = 1'b1; end
            4'd4:  begin e.result = alu_xor;  e.wen = 1'b1; end
            4'd5:  begin e.result = alu_sll;  e.wen = 1'b1; end
            4'd6:  begin e.result = alu_srl;  e.wen = 1'b1; end
            4'd7:  begin e.result = alu_slt;  e.wen = 1'b1; end
            4'd8:  begin e.result = alu_sltu; e.wen = 1'b1; end
            4'd9:  e.taken = alu_eq;
            4'd10: e.taken = !alu_eq;
            4'd11: e.taken = alu_slt[0];
            4'd12: e.taken = !alu_slt[0];
            4'd13: e.taken = alu_sltu[0];
            4'd14: e.taken = !alu_sltu[0];
            default: ;
        endcase
        e.rd     = e.wen ? in_rd : 5'd0;
        e.target = in_pc + in_imm;
        return e;
    endfunction

    task automatic rand_alu();
        alu_add  = $urandom; alu_sub  = $urandom; alu_and = $urandom;
        alu_or   = $urandom; alu_xor  = $urandom; alu_sll = $urandom;
        alu_srl  = $urandom; alu_slt  = {31'd0, 1'($urandom_range(0, 1))};
        alu_sltu = {31'd0, 1'($urandom_range(0, 1))};
        alu_eq   = 1'($urandom_range(0, 1));
    endtask

    task automatic set_in(input logic v, input logic [3:0] op, input logic [4:0] rd,
                          input logic [31:0] pc, input logic [31:0] imm);
        in_valid = v; in_op = op; in_rd = rd; in_pc = pc; in_imm = imm;
    endtask

    // Check the head against the scoreboard, update the model, advance a cycle.
    task automatic cycle();
        logic acc, popd;
        #3;
        check_eq("valid", out_valid, q.size() != 0);
`ifdef EX_SKID_EN
        check_eq("in_ready", in_ready, q.size() < 2);
`else
        check_eq("in_ready", in_ready, (q.size() == 0) || out_ready);
`endif
        if (q.size() != 0 && out_valid) begin
            check_eq("result", out_result, q[0].result);
            check_eq("rd", out_rd, q[0].rd);
            check_eq("wen", out_wen, q[0].wen);
            check_eq("taken", out_br_taken, q[0].taken);
            check_eq("target", out_br_target, q[0].target);
        end
        acc  = in_valid & in_ready & !flush;
        popd = out_valid & out_ready;
        if (popd && q.size() != 0) void'(q.pop_front());
        if (flush) q.delete();
        else if (acc) q.push_back(model());
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 4'd15, 5'd0, 32'h0, 32'h0);
        rand_alu();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_result", out_result, 32'h0);
        check_eq("rst_rd", out_rd, 5'd0);
        check_eq("rst_wen", out_wen, 1'b0);
        check_eq("rst_taken", out_br_taken, 1'b0);
        check_eq("rst_target", out_br_target, 32'h0);

        // ADD writes rd=3.
        out_ready = 1'b1;
        alu_add = 32'h7;
        set_in(1'b1, 4'd0, 5'd3, 32'h0, 32'h0);
        cycle();
        set_in(1'b0, 4'd15, 5'd0, 32'h0, 32'h0);
        check_eq("add_valid", out_valid, 1'b1);
        check_eq("add_result", out_result, 32'h7);
        check_eq("add_wen", out_wen, 1'b1);
        check_eq("add_rd", out_rd, 5'd3);
        cycle();

        // BLT taken with negative offset.
        alu_slt = 32'h1;
        set_in(1'b1, 4'd11, 5'd9, 32'h100, 32'hFFFF_FFF0);
        cycle();
        set_in(1'b0, 4'd15, 5'd0, 32'h0, 32'h0);
        check_eq("blt_taken", out_br_taken, 1'b1);
        check_eq("blt_target", out_br_target, 32'hF0);
        check_eq("blt_wen", out_wen, 1'b0);
        check_eq("blt_rd", out_rd, 5'd0);
        cycle();

        // BGEU with wrap-around target.
        alu_sltu = 32'h0;
        set_in(1'b1, 4'd14, 5'd1, 32'hFFFF_FFFC, 32'h8);
        cycle();
        set_in(1'b0, 4'd15, 5'd0, 32'h0, 32'h0);
        check_eq("bgeu_taken", out_br_taken, 1'b1);
        check_eq("bgeu_target", out_br_target, 32'h4);
        cycle();

        // SUB then XOR into a stalled stage, then drain in order.
        out_ready = 1'b0;
        alu_sub = 32'h1111; alu_xor = 32'h2222;
        set_in(1'b1, 4'd1, 5'd4, 32'h0, 32'h0);
        cycle();
        set_in(1'b1, 4'd4, 5'd5, 32'h0, 32'h0);
        cycle();
        set_in(1'b0, 4'd15, 5'd0, 32'h0, 32'h0);
`ifdef EX_SKID_EN
        check_eq("stall_in_ready", in_ready, 1'b0);
`endif
        check_eq("stall_head", out_result, 32'h1111);
        cycle();
        out_ready = 1'b1;
        repeat (3) cycle();

        // Flush with a full buffer and a valid input: everything dropped.
        out_ready = 1'b0;
        rand_alu();
        set_in(1'b1, 4'd2, 5'd6, 32'h0, 32'h0);
        cycle();
        set_in(1'b1, 4'd3, 5'd7, 32'h0, 32'h0);
        cycle();
        flush = 1'b1;
        set_in(1'b1, 4'd0, 5'd8, 32'h0, 32'h0);
        cycle();
        flush = 1'b0;
        set_in(1'b0, 4'd15, 5'd0, 32'h0, 32'h0);
        check_eq("flush_valid", out_valid, 1'b0);
        check_eq("flush_in_ready", in_ready, 1'b1);
        cycle();

        // Random traffic with random stalls and occasional flushes.
        for (int i = 0; i < 300; i++) begin
            rand_alu();
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            set_in(1'($urandom_range(0, 3) != 0), 4'($urandom), 5'($urandom), $urandom, $urandom);
            cycle();
        end
        flush = 1'b0;

        // Reset mid-operation discards buffered entries and the handshake.
        out_ready = 1'b0;
        set_in(1'b1, 4'd0, 5'd2, 32'h0, 32'h0);
        cycle();
        out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        set_in(1'b0, 4'd15, 5'd0, 32'h0, 32'h0);
        check_eq("mid_rst_valid", out_valid, 1'b0);
        check_eq("mid_rst_in_ready", in_ready, 1'b1);
        check_eq("mid_rst_result", out_result, 32'h0);
        check_eq("mid_rst_wen", out_wen, 1'b0);
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
